// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and constants for the vectored interrupt
//               controller (controller state encoding, datapath width).
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Single-bit synchroniser chain for one asynchronous interrupt
//               source.
// Ports       : clk   - clock
//               rst_n - asynchronous reset, active-low
//               d_i   - raw asynchronous input
//               q_o   - synchronised output (STAGES flops of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule : irq_sync
`default_nettype wire

// File: rtl/irq_vec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_vec_ctrl
// Description : N-channel vectored interrupt controller. Synchronises raw
//               sources, latches pending per channel (edge or level mode),
//               masks, picks the lowest-index eligible channel and requests a
//               fetch redirect via a req/take handshake. Holds the return PC.
// Ports       : clk        - clock
//               rst        - asynchronous reset, active-low
//               irq_in     - raw asynchronous interrupt sources
//               irq_mask   - per-channel enable (1 = enabled)
//               global_en  - allows new requests to be raised
//               take       - fetch accepted the redirect this cycle
//               epc_in     - PC of interrupted instruction, valid with take
//               mret       - handler return
//               irq_req    - redirect request
//               irq_addr   - handler vector, valid while irq_req
//               irq_id     - served channel
//               in_service - handler executing
//               epc_out    - saved return PC
//               pending    - pending register (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_vec_ctrl
  import irq_pkg::*;
#(
  parameter int               N_IRQ       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = {N_IRQ{1'b1}},
  parameter logic [XLEN-1:0]  BASE_ADDR   = 32'h0000_0100,
  parameter int               VEC_STRIDE  = 4,
  localparam int              IDW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             global_en,
  input  logic             take,
  input  logic [XLEN-1:0]  epc_in,
  input  logic             mret,
  output logic             irq_req,
  output logic [XLEN-1:0]  irq_addr,
  output logic [IDW-1:0]   irq_id,
  output logic             in_service,
  output logic [XLEN-1:0]  epc_out,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] sync_s;
  logic [N_IRQ-1:0] sync_s_d_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] eligible;
  logic [IDW-1:0]   winner;
  logic             take_ok;

  irq_state_t       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  generate
    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      irq_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (irq_in[g]),
        .q_o   (sync_s[g])
      );
    end
  endgenerate

  // Lowest set index wins; scanning downward lets lower indices overwrite.
  function automatic logic [IDW-1:0] prio_enc(input logic [N_IRQ-1:0] vec);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  assign eligible = pending_q & irq_mask;
  assign winner   = prio_enc(eligible);
  // A take only counts while a request is actually outstanding.
  assign take_ok  = take && (state_q == IRQ_REQ);

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        if (take_ok && (id_q == IDW'(i))) pending_d[i] = 1'b0;
        // Applied after the clear so a fresh edge in the take cycle survives.
        if (sync_s[i] && !sync_s_d_q[i]) pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = sync_s[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    epc_d   = epc_q;
    case (state_q)
      IRQ_IDLE: begin
        if (global_en && (|eligible)) begin
          state_d = IRQ_REQ;
          id_d    = winner;
          addr_d  = BASE_ADDR + (XLEN'(winner) * XLEN'(VEC_STRIDE));
        end
      end
      IRQ_REQ: begin
        // id/addr stay frozen; only take or loss of the served channel exit.
        if (take) begin
          state_d = IRQ_SERVICE;
          epc_d   = epc_in;
        end else if (!eligible[id_q]) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (mret) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IRQ_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      epc_q      <= '0;
      pending_q  <= '0;
      sync_s_d_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      epc_q      <= epc_d;
      pending_q  <= pending_d;
      sync_s_d_q <= sync_s;
    end
  end

  assign irq_req    = (state_q == IRQ_REQ);
  assign in_service = (state_q == IRQ_SERVICE);
  assign irq_id     = id_q;
  assign irq_addr   = addr_q;
  assign epc_out    = epc_q;
  assign pending    = pending_q;

endmodule : irq_vec_ctrl
`default_nettype wire

// File: tb/tb_irq_vec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_vec_ctrl
// Description : Directed self-checking bench for irq_vec_ctrl. Channel 0 is
//               level-mode, channels 1..3 edge-mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_vec_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic [3:0]  irq_mask;
  logic        global_en;
  logic        take;
  logic [31:0] epc_in;
  logic        mret;
  logic        irq_req;
  logic [31:0] irq_addr;
  logic [1:0]  irq_id;
  logic        in_service;
  logic [31:0] epc_out;
  logic [3:0]  pending;

  int tests;
  int failed;

  irq_vec_ctrl #(
    .N_IRQ       (4),
    .SYNC_STAGES (2),
    .EDGE_MASK   (4'b1110),
    .BASE_ADDR   (32'h0000_0100),
    .VEC_STRIDE  (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .global_en  (global_en),
    .take       (take),
    .epc_in     (epc_in),
    .mret       (mret),
    .irq_req    (irq_req),
    .irq_addr   (irq_addr),
    .irq_id     (irq_id),
    .in_service (in_service),
    .epc_out    (epc_out),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [31:0] pc);
    take   = 1'b1;
    epc_in = pc;
    tick(1);
    take   = 1'b0;
    check("serve_in_service", 32'(in_service), 32'd1);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("serve_idle", 32'(in_service), 32'd0);
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b0;
    irq_in    = 4'h0;
    irq_mask  = 4'hF;
    global_en = 1'b1;
    take      = 1'b0;
    epc_in    = 32'h0;
    mret      = 1'b0;

    // Reset state
    tick(2);
    check("rst_req",     32'(irq_req),    32'd0);
    check("rst_insvc",   32'(in_service), 32'd0);
    check("rst_pending", 32'(pending),    32'd0);
    check("rst_epc",     epc_out,         32'd0);
    rst = 1'b1;
    tick(1);

    // Edge ch2: latency and vector
    irq_in = 4'b0100;               // just after edge 0
    tick(2);
    check("e2_pend_e2", 32'(pending), 32'h0);
    tick(1);
    check("e2_pend_e3", 32'(pending), 32'h4);
    check("e2_req_e3",  32'(irq_req), 32'd0);
    tick(1);
    check("e2_req_e4",  32'(irq_req), 32'd1);
    check("e2_id",      32'(irq_id),  32'd2);
    check("e2_addr",    irq_addr,     32'h108);
    take = 1'b1; epc_in = 32'h40;
    tick(1);
    take = 1'b0;
    check("e2_insvc",   32'(in_service), 32'd1);
    check("e2_req_off", 32'(irq_req),    32'd0);
    check("e2_epc",     epc_out,         32'h40);
    check("e2_pend_clr", 32'(pending),   32'h0);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("e2_mret_insvc", 32'(in_service), 32'd0);
    check("e2_mret_req",   32'(irq_req),    32'd0);
    check("e2_epc_held",   epc_out,         32'h40);
    irq_in = 4'h0;
    tick(3);

    // Priority: ch1 and ch3 together
    irq_in = 4'b1010;
    tick(4);
    check("pr_req",  32'(irq_req), 32'd1);
    check("pr_id1",  32'(irq_id),  32'd1);
    check("pr_addr1", irq_addr,    32'h104);
    check("pr_pend", 32'(pending), 32'hA);
    take = 1'b1; epc_in = 32'h80;
    tick(1);
    take = 1'b0;
    check("pr_pend_after", 32'(pending), 32'h8);
    check("pr_epc",        epc_out,      32'h80);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("pr_gap_req", 32'(irq_req), 32'd0);
    tick(1);
    check("pr_req3",  32'(irq_req), 32'd1);
    check("pr_id3",   32'(irq_id),  32'd3);
    check("pr_addr3", irq_addr,     32'h10C);
    serve(32'hC0);
    check("pr_pend_end", 32'(pending), 32'h0);
    irq_in = 4'h0;
    tick(3);

    // Nesting: ch2 arrives while ch1 is in service
    irq_in = 4'b0010;
    tick(4);
    check("ne_id1", 32'(irq_id), 32'd1);
    take = 1'b1; epc_in = 32'h200;
    irq_in = 4'b0110;
    tick(1);
    take = 1'b0;
    check("ne_insvc", 32'(in_service), 32'd1);
    tick(3);
    check("ne_pend",  32'(pending),    32'h4);
    check("ne_noreq", 32'(irq_req),    32'd0);
    tick(2);
    check("ne_noreq2", 32'(irq_req),   32'd0);
    check("ne_insvc2", 32'(in_service), 32'd1);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    check("ne_mret_req", 32'(irq_req), 32'd0);
    tick(1);
    check("ne_req2",  32'(irq_req), 32'd1);
    check("ne_id2",   32'(irq_id),  32'd2);
    check("ne_addr2", irq_addr,     32'h108);
    serve(32'h204);
    irq_in = 4'h0;
    tick(3);

    // New ch1 edge in its own take cycle keeps pending[1]
    irq_in = 4'b0010;               // edge 0
    tick(1);
    irq_in = 4'b0000;               // edge 1
    tick(1);
    irq_in = 4'b0010;               // edge 2
    tick(1);
    check("sw_pend_e3", 32'(pending), 32'h2);
    tick(1);
    check("sw_req_e4",  32'(irq_req), 32'd1);
    take = 1'b1; epc_in = 32'h300;
    tick(1);
    take = 1'b0;
    check("sw_pend_kept", 32'(pending),    32'h2);
    check("sw_insvc",     32'(in_service), 32'd1);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    tick(1);
    check("sw_req_again", 32'(irq_req), 32'd1);
    check("sw_id_again",  32'(irq_id),  32'd1);
    serve(32'h304);
    irq_in = 4'h0;
    tick(3);
    check("sw_pend_end", 32'(pending), 32'h0);

    // Mask and global enable
    irq_mask = 4'b0111;
    irq_in   = 4'b1000;
    tick(6);
    check("mk_pend",  32'(pending), 32'h8);
    check("mk_noreq", 32'(irq_req), 32'd0);
    irq_mask = 4'hF;
    tick(1);
    check("mk_req",  32'(irq_req), 32'd1);
    check("mk_id",   32'(irq_id),  32'd3);
    global_en = 1'b0;
    tick(1);
    check("mk_gen_noretract", 32'(irq_req), 32'd1);
    serve(32'h400);
    irq_in = 4'b0100;
    tick(6);
    check("ge_pend",  32'(pending), 32'h4);
    check("ge_noreq", 32'(irq_req), 32'd0);
    global_en = 1'b1;
    tick(1);
    check("ge_req", 32'(irq_req), 32'd1);
    check("ge_id",  32'(irq_id),  32'd2);
    serve(32'h404);
    irq_in = 4'h0;
    tick(3);

    // Retract: level ch0 drops before take
    irq_in = 4'b0001;               // edge 0
    tick(3);
    check("rt_pend_e3", 32'(pending), 32'h1);
    tick(1);
    check("rt_req_e4", 32'(irq_req), 32'd1);
    check("rt_id",     32'(irq_id),  32'd0);
    check("rt_addr",   irq_addr,     32'h100);
    irq_in = 4'b0000;
    tick(2);
    check("rt_pend_e6", 32'(pending), 32'h1);
    tick(1);
    check("rt_pend_e7", 32'(pending), 32'h0);
    check("rt_req_e7",  32'(irq_req), 32'd1);
    tick(1);
    check("rt_req_e8",   32'(irq_req),    32'd0);
    check("rt_insvc_e8", 32'(in_service), 32'd0);
    tick(3);
    check("rt_req_late",   32'(irq_req),    32'd0);
    check("rt_insvc_late", 32'(in_service), 32'd0);

    // Reset during service
    irq_in = 4'b0100;
    tick(4);
    check("rs_req", 32'(irq_req), 32'd1);
    take = 1'b1; epc_in = 32'h1234;
    tick(1);
    take = 1'b0;
    check("rs_insvc", 32'(in_service), 32'd1);
    check("rs_epc",   epc_out,         32'h1234);
    rst = 1'b0;
    #1;
    check("rs_async_insvc", 32'(in_service), 32'd0);
    tick(1);
    check("rs_req0",   32'(irq_req),    32'd0);
    check("rs_insvc0", 32'(in_service), 32'd0);
    check("rs_epc0",   epc_out,         32'd0);
    check("rs_pend0",  32'(pending),    32'd0);
    check("rs_id0",    32'(irq_id),     32'd0);
    check("rs_addr0",  irq_addr,        32'd0);
    irq_in = 4'h0;
    rst    = 1'b1;
    tick(6);
    check("rs_post_req",  32'(irq_req), 32'd0);
    check("rs_post_pend", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_irq_vec_ctrl
`default_nettype wire
